// File: rtl/udp_rx.sv
// ============================================================================
// Module   : udp_rx
// Summary  : Receive-side UDP stage. Parses the 8-byte UDP header, filters on
//            destination port, strips Ethernet padding using the UDP length
//            field and forwards payload bytes to the application layer.
// Options  : define UDP_LEN_CHECK_EN to reject segments whose UDP length
//            exceeds the length reported by the IP stage (i_udp_len).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_rx #(
  parameter logic [15:0] P_LOCAL_PORT = 16'd8080,
  parameter int          P_HDR_LEN    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_local_port,
  input  logic        i_local_port_valid,
  input  logic [7:0]  i_udp_data,
  input  logic [15:0] i_udp_len,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  output logic [7:0]  o_app_data,
  output logic [15:0] o_app_len,
  output logic        o_app_last,
  output logic        o_app_valid,
  output logic        o_app_err,
  output logic [15:0] o_recv_src_port,
  output logic        o_recv_src_valid
);

  localparam logic [15:0] C_HDR_LEN  = 16'(P_HDR_LEN);
  localparam logic [15:0] C_HDR_LAST = 16'(P_HDR_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;       // byte index within the current segment
  logic [15:0] r_local;     // programmable local port
  logic [15:0] r_cmp_port;  // local port snapshot used for this segment
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_ulen;
  logic [15:0] r_plen;      // payload length, UDP length minus header
  logic        r_armed;     // i_udp_valid has been seen low since last start

  logic        w_len_ok;
  logic        w_pay_last;
  logic        w_capture;

`ifdef UDP_LEN_CHECK_EN
  // UDP length may not claim more bytes than the IP stage delivers.
  assign w_len_ok = (r_ulen <= i_udp_len);
  logic w_unused;
  assign w_unused = i_udp_last;
`else
  // Without the check, the IP-reported length plays no role.
  assign w_len_ok = 1'b1;
  logic w_unused;
  assign w_unused = ^{i_udp_len, i_udp_last};
`endif

  // Byte at index r_cnt is payload byte number (r_cnt - 7), counting from 1.
  assign w_pay_last = ((r_cnt - C_HDR_LAST) == r_plen);

  // Header bytes are only captured for a segment that actually started.
  assign w_capture = i_udp_valid &&
                     ((r_state == S_HEADER) || ((r_state == S_IDLE) && r_armed));

  // Local port register, loadable at any time.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_local <= P_LOCAL_PORT;
    end else if (i_local_port_valid) begin
      r_local <= i_local_port;
    end
  end

  // Segment byte counter: index 0 is the first byte, cleared between segments.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_udp_valid) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Header field capture, MSB first; checksum bytes are not kept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src  <= 16'd0;
      r_dst  <= 16'd0;
      r_ulen <= 16'd0;
    end else if (w_capture) begin
      case (r_cnt)
        16'd0:   r_src[15:8]  <= i_udp_data;
        16'd1:   r_src[7:0]   <= i_udp_data;
        16'd2:   r_dst[15:8]  <= i_udp_data;
        16'd3:   r_dst[7:0]   <= i_udp_data;
        16'd4:   r_ulen[15:8] <= i_udp_data;
        16'd5:   r_ulen[7:0]  <= i_udp_data;
        default: ;
      endcase
    end
  end

  // Segment FSM with registered application-side outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_armed          <= 1'b0;
      r_cmp_port       <= P_LOCAL_PORT;
      r_plen           <= 16'd0;
      o_app_data       <= 8'd0;
      o_app_len        <= 16'd0;
      o_app_last       <= 1'b0;
      o_app_valid      <= 1'b0;
      o_app_err        <= 1'b0;
      o_recv_src_port  <= 16'd0;
      o_recv_src_valid <= 1'b0;
    end else begin
      o_app_data       <= i_udp_data;
      o_app_valid      <= 1'b0;
      o_app_last       <= 1'b0;
      o_app_err        <= 1'b0;
      o_recv_src_valid <= 1'b0;

      if (!i_udp_valid) begin
        // End of input: a segment cut short in header or payload is an error.
        r_armed <= 1'b1;
        r_state <= S_IDLE;
        if ((r_state == S_HEADER) || (r_state == S_PAYLOAD)) begin
          o_app_err <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            // A segment only starts on the first byte after a low gap, so
            // the tail of a segment interrupted by reset is never parsed.
            if (r_armed) begin
              r_armed    <= 1'b0;
              r_cmp_port <= r_local;
              r_state    <= S_HEADER;
            end
          end

          S_HEADER: begin
            if (r_cnt == C_HDR_LAST) begin
              if (r_ulen < C_HDR_LEN) begin
                o_app_err <= 1'b1;
                r_state   <= S_DROP;
              end else if (!w_len_ok) begin
                o_app_err <= 1'b1;
                r_state   <= S_DROP;
              end else if (r_dst != r_cmp_port) begin
                r_state <= S_DROP;
              end else begin
                o_recv_src_port  <= r_src;
                o_recv_src_valid <= 1'b1;
                o_app_len        <= r_ulen - C_HDR_LEN;
                r_plen           <= r_ulen - C_HDR_LEN;
                // Header-only segment: remaining bytes are padding and are
                // ignored in IDLE until the input goes low.
                r_state <= (r_ulen == C_HDR_LEN) ? S_IDLE : S_PAYLOAD;
              end
            end
          end

          S_PAYLOAD: begin
            o_app_valid <= 1'b1;
            if (w_pay_last) begin
              o_app_last <= 1'b1;
              r_state    <= S_DROP;
            end
          end

          S_DROP: begin
            r_state <= S_DROP;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
